// File: rtl/dsp_irq_pkg.sv
// Shared types and defaults for the DSP interrupt stretcher.
package dsp_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } irq_state_t;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_PULSE_LEN = 100;
    localparam int DEF_GAP_LEN   = 4;
    localparam int DEF_CNT_W     = 11;

    function automatic int ch_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_rr_arbiter.sv
// Combinational round-robin pick among pending channels, searching from last_grant+1.
module irq_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [ID_W-1:0]   last_grant,
    output logic              grant_valid,
    output logic [ID_W-1:0]   grant_id
);

    logic [ID_W-1:0] idx;

    // Walk the ring once; the first pending channel after last_grant wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = last_grant;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (idx == ID_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
            if (pending[idx] && !grant_valid) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/dsp_irq_ctrl.sv
// Merges per-channel level requests into stretched, gap-separated DSP interrupt pulses.
// Optional macro DSP_IRQ_ACK_EN lets irq_ack cut a pulse short.
module dsp_irq_ctrl
    import dsp_irq_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int PULSE_LEN = DEF_PULSE_LEN,
    parameter int GAP_LEN   = DEF_GAP_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                        clk_50m,
    input  logic                        cfg_rst,
    input  logic [NUM_CH-1:0]           read_quest,
    input  logic                        slot_interrupt,
    input  logic                        irq_ack,
    output logic                        dsp_receive_interrupt,
    output logic [ch_id_w(NUM_CH)-1:0]  irq_ch_id,
    output logic [NUM_CH*CNT_W-1:0]     irq_count,
    output logic [NUM_CH-1:0]           irq_drop,
    output logic                        busy
);

    localparam int         ID_W       = ch_id_w(NUM_CH);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_LAST   = 8'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    irq_state_t        state, state_nxt;
    logic [7:0]        tmr;
    logic [NUM_CH-1:0] read_quest_dl, rise, pending, gnt_clr, drop_set;
    logic [ID_W-1:0]   last_grant, grant_id;
    logic              grant_valid, grant_take, ack_hit, irq_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign rise       = read_quest & ~read_quest_dl;
    assign grant_take = (state_nxt == ST_ASSERT) && (state != ST_ASSERT);
    assign drop_set   = rise & pending & ~gnt_clr;

`ifdef DSP_IRQ_ACK_EN
    assign ack_hit = irq_ack & dsp_receive_interrupt & (state == ST_ASSERT);
`else
    logic unused_ack;
    assign unused_ack = irq_ack;
    assign ack_hit    = 1'b0;
`endif

    always_comb begin
        gnt_clr = '0;
        if (grant_take) gnt_clr[grant_id] = 1'b1;
    end

    irq_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_arb (
        .pending     (pending),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk_50m or posedge cfg_rst) begin
        if (cfg_rst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // The last GAP cycle may grant directly so the low time is exactly GAP_LEN.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (grant_valid) state_nxt = ST_ASSERT;
            ST_ASSERT: if (ack_hit || tmr == PULSE_LAST)
                           state_nxt = (GAP_LEN > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:    if (tmr == GAP_LAST)
                           state_nxt = grant_valid ? ST_ASSERT : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != ST_IDLE);
        irq_d = (state == ST_ASSERT) & ~ack_hit;
    end

    // The interrupt is a registered image of ASSERT, giving the two-edge request latency.
    always_ff @(posedge clk_50m or posedge cfg_rst) begin
        if (cfg_rst) begin
            read_quest_dl         <= '0;
            pending               <= '0;
            tmr                   <= '0;
            dsp_receive_interrupt <= 1'b0;
            irq_ch_id             <= '0;
            last_grant            <= ID_W'(NUM_CH - 1);
            irq_drop              <= '0;
        end else begin
            read_quest_dl         <= read_quest;
            pending               <= (pending & ~gnt_clr) | rise;
            tmr                   <= (state_nxt != state || state == ST_IDLE) ? 8'd0 : tmr + 8'd1;
            dsp_receive_interrupt <= irq_d;
            irq_drop              <= slot_interrupt ? drop_set : (irq_drop | drop_set);
            if (grant_take) begin
                irq_ch_id  <= grant_id;
                last_grant <= grant_id;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        always_ff @(posedge clk_50m or posedge cfg_rst) begin
            if (cfg_rst)             cnt_q[g] <= '0;
            else if (slot_interrupt) cnt_q[g] <= rise[g] ? CNT_W'(1) : '0;
            else if (rise[g])        cnt_q[g] <= sat_inc(cnt_q[g]);
        end
        assign irq_count[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule

// File: tb/tb_dsp_irq_ctrl.sv
// Directed bench for dsp_irq_ctrl: default instance plus a small-counter, no-gap instance.
module tb_dsp_irq_ctrl;

    logic        clk_50m = 1'b0;
    logic        cfg_rst;
    logic [3:0]  read_quest;
    logic        slot_interrupt;
    logic        irq_ack;
    logic        dsp_receive_interrupt;
    logic [1:0]  irq_ch_id;
    logic [43:0] irq_count;
    logic [3:0]  irq_drop;
    logic        busy;

    logic [3:0]  rq2;
    logic        rx2, busy2;
    logic [1:0]  id2;
    logic [11:0] cnt2;
    logic [3:0]  drop2;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DSP_IRQ_ACK_EN
    localparam int ACK_LEN = 5;
`else
    localparam int ACK_LEN = 100;
`endif

    always #10 clk_50m = ~clk_50m;

    dsp_irq_ctrl dut (
        .clk_50m               (clk_50m),
        .cfg_rst               (cfg_rst),
        .read_quest            (read_quest),
        .slot_interrupt        (slot_interrupt),
        .irq_ack               (irq_ack),
        .dsp_receive_interrupt (dsp_receive_interrupt),
        .irq_ch_id             (irq_ch_id),
        .irq_count             (irq_count),
        .irq_drop              (irq_drop),
        .busy                  (busy)
    );

    dsp_irq_ctrl #(.NUM_CH(4), .PULSE_LEN(2), .GAP_LEN(0), .CNT_W(3)) dut2 (
        .clk_50m               (clk_50m),
        .cfg_rst               (cfg_rst),
        .read_quest            (rq2),
        .slot_interrupt        (1'b0),
        .irq_ack               (1'b0),
        .dsp_receive_interrupt (rx2),
        .irq_ch_id             (id2),
        .irq_count             (cnt2),
        .irq_drop              (drop2),
        .busy                  (busy2)
    );

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic wait_irq(input logic lvl, input int max_cyc, output int waited);
        waited = 0;
        while (dsp_receive_interrupt !== lvl && waited < max_cyc) begin
            tick();
            waited++;
        end
    endtask

    task automatic wait_idle(input int max_cyc, output int waited);
        waited = 0;
        while (busy !== 1'b0 && waited < max_cyc) begin
            tick();
            waited++;
        end
    endtask

    // Counts high cycles of the current pulse; raises irq_ack during high cycle ack_at.
    task automatic measure_high(input int ack_at, output int len);
        len = 0;
        while (dsp_receive_interrupt === 1'b1 && len < 400) begin
            len++;
            if (len == ack_at) irq_ack = 1'b1;
            tick();
            irq_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        cfg_rst = 1'b1; read_quest = '0; rq2 = '0; slot_interrupt = 1'b0; irq_ack = 1'b0;
        repeat (3) tick();
        n_checks++; if (dsp_receive_interrupt !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", dsp_receive_interrupt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (irq_count !== 44'd0) begin n_fail++; $display("FAIL rst_count: got %h want 0", irq_count); end
        n_checks++; if (irq_drop !== 4'd0) begin n_fail++; $display("FAIL rst_drop: got %b want 0", irq_drop); end
        n_checks++; if (irq_ch_id !== 2'd0) begin n_fail++; $display("FAIL rst_id: got %0d want 0", irq_ch_id); end
        n_checks++; if ({rx2, busy2, id2, cnt2, drop2} !== 20'd0) begin n_fail++; $display("FAIL rst_dut2: got %h want 0", {rx2, busy2, id2, cnt2, drop2}); end
        cfg_rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int len, w;
        read_quest[0] = 1'b1;
        tick();
        n_checks++; if (dsp_receive_interrupt !== 1'b0) begin n_fail++; $display("FAIL lat_k: got %b want 0", dsp_receive_interrupt); end
        tick();
        n_checks++; if (dsp_receive_interrupt !== 1'b0) begin n_fail++; $display("FAIL lat_k1: got %b want 0", dsp_receive_interrupt); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy: got %b want 1", busy); end
        tick();
        n_checks++; if (dsp_receive_interrupt !== 1'b1) begin n_fail++; $display("FAIL lat_k2: got %b want 1", dsp_receive_interrupt); end
        n_checks++; if (irq_ch_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d want 0", irq_ch_id); end
        measure_high(0, len);
        n_checks++; if (len != 100) begin n_fail++; $display("FAIL single_len: got %0d want 100", len); end
        n_checks++; if (irq_count[10:0] !== 11'd1) begin n_fail++; $display("FAIL single_cnt: got %0d want 1", irq_count[10:0]); end
        read_quest[0] = 1'b0;
        wait_idle(20, w);
        n_checks++; if (w >= 20) begin n_fail++; $display("FAIL single_idle: waited %0d want <20", w); end
    endtask

    task automatic test_two_channels();
        int len, w;
        read_quest = 4'b1010;
        wait_irq(1'b1, 10, w);
        n_checks++; if (w >= 10) begin n_fail++; $display("FAIL two_start: waited %0d want <10", w); end
        n_checks++; if (irq_ch_id !== 2'd1) begin n_fail++; $display("FAIL two_id1: got %0d want 1", irq_ch_id); end
        measure_high(0, len);
        n_checks++; if (len != 100) begin n_fail++; $display("FAIL two_len1: got %0d want 100", len); end
        wait_irq(1'b1, 20, w);
        n_checks++; if (w != 4) begin n_fail++; $display("FAIL two_gap: got %0d low cycles want 4", w); end
        n_checks++; if (irq_ch_id !== 2'd3) begin n_fail++; $display("FAIL two_id3: got %0d want 3", irq_ch_id); end
        measure_high(0, len);
        n_checks++; if (len != 100) begin n_fail++; $display("FAIL two_len3: got %0d want 100", len); end
        n_checks++; if (irq_drop !== 4'd0) begin n_fail++; $display("FAIL two_drop: got %b want 0000", irq_drop); end
        read_quest = '0;
        wait_idle(20, w);
    endtask

    task automatic test_drop_and_slot();
        int w;
        read_quest[1] = 1'b1;
        wait_irq(1'b1, 10, w);
        repeat (5) tick();
        read_quest[2] = 1'b1; tick();
        read_quest[2] = 1'b0; tick();
        read_quest[2] = 1'b1; tick();
        read_quest[2] = 1'b0; tick();
        n_checks++; if (irq_drop !== 4'b0100) begin n_fail++; $display("FAIL drop_flag: got %b want 0100", irq_drop); end
        n_checks++; if (irq_count[32:22] !== 11'd2) begin n_fail++; $display("FAIL drop_cnt: got %0d want 2", irq_count[32:22]); end
        slot_interrupt = 1'b1; tick();
        slot_interrupt = 1'b0;
        n_checks++; if (irq_count !== 44'd0) begin n_fail++; $display("FAIL slot_cnt: got %h want 0", irq_count); end
        n_checks++; if (irq_drop !== 4'd0) begin n_fail++; $display("FAIL slot_drop: got %b want 0000", irq_drop); end
        wait_irq(1'b0, 200, w);
        wait_irq(1'b1, 20, w);
        n_checks++; if (w >= 20) begin n_fail++; $display("FAIL slot_pending: waited %0d want <20", w); end
        n_checks++; if (irq_ch_id !== 2'd2) begin n_fail++; $display("FAIL slot_id: got %0d want 2", irq_ch_id); end
        read_quest[1] = 1'b0;
        wait_idle(200, w);
    endtask

    task automatic test_saturate();
        repeat (3) begin rq2[0] = 1'b1; tick(); rq2[0] = 1'b0; tick(); end
        n_checks++; if (cnt2[2:0] !== 3'd3) begin n_fail++; $display("FAIL sat_cnt3: got %0d want 3", cnt2[2:0]); end
        repeat (7) begin rq2[0] = 1'b1; tick(); rq2[0] = 1'b0; tick(); end
        n_checks++; if (cnt2[2:0] !== 3'd7) begin n_fail++; $display("FAIL sat_cnt7: got %0d want 7", cnt2[2:0]); end
        n_checks++; if (cnt2[11:3] !== 9'd0) begin n_fail++; $display("FAIL sat_other: got %h want 0", cnt2[11:3]); end
    endtask

    task automatic test_ack();
        int len, w;
        read_quest[0] = 1'b1;
        wait_irq(1'b1, 10, w);
        measure_high(5, len);
        n_checks++; if (len != ACK_LEN) begin n_fail++; $display("FAIL ack_len: got %0d want %0d", len, ACK_LEN); end
        read_quest[0] = 1'b0;
        wait_idle(20, w);
    endtask

    task automatic test_reset_mid_pulse();
        int w;
        bit seen;
        read_quest[0] = 1'b1;
        wait_irq(1'b1, 10, w);
        repeat (9) tick();
        read_quest[2] = 1'b1;
        repeat (40) tick();
        n_checks++; if (dsp_receive_interrupt !== 1'b1) begin n_fail++; $display("FAIL mid_active: got %b want 1", dsp_receive_interrupt); end
        cfg_rst = 1'b1;
        read_quest = '0;
        #1;
        n_checks++; if (dsp_receive_interrupt !== 1'b0) begin n_fail++; $display("FAIL mid_irq: got %b want 0", dsp_receive_interrupt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_checks++; if (irq_count !== 44'd0) begin n_fail++; $display("FAIL mid_count: got %h want 0", irq_count); end
        n_checks++; if (irq_drop !== 4'd0) begin n_fail++; $display("FAIL mid_drop: got %b want 0", irq_drop); end
        tick();
        cfg_rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (dsp_receive_interrupt !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_nopulse: got %b want 0", seen); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_after: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_channels();
        test_drop_and_slot();
        test_saturate();
        test_ack();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dsp_irq_ctrl.md
DSP_IRQ_CTRL -- requirements
Module: dsp_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of request channels (1..8).
REQ-002 SHALL have parameter PULSE_LEN, default 100, interrupt high time in clk_50m cycles (1..255).
REQ-003 SHALL have parameter GAP_LEN, default 4, forced low time after each pulse in cycles (0..255).
REQ-004 SHALL have parameter CNT_W, default 11, width of per-channel request counters.
REQ-005 SHALL have port clk_50m  in  1  clock; all logic on rising edge.
REQ-006 SHALL have port cfg_rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port read_quest  in  NUM_CH  per-channel level requests, synchronous to clk_50m.
REQ-008 SHALL have port slot_interrupt  in  1  slot boundary strobe; clears statistics.
REQ-009 SHALL have port irq_ack  in  1  DSP acknowledge.
REQ-010 SHALL have port dsp_receive_interrupt  out  1  stretched interrupt to DSP.
REQ-011 SHALL have port irq_ch_id  out  max(1,clog2(NUM_CH))  channel being signalled.
REQ-012 SHALL have port irq_count  out  NUM_CH*CNT_W  per-channel request counts; channel i at [i*CNT_W +: CNT_W].
REQ-013 SHALL have port irq_drop  out  NUM_CH  sticky per-channel lost-request flags.
REQ-014 SHALL have port busy  out  1  high whenever FSM not IDLE.

Function
REQ-015 SHALL register read_quest into read_quest_dl; rise[i] = read_quest[i] & ~read_quest_dl[i].
REQ-016 SHALL set pending[i] on rise[i]; clear it on grant; rise and grant on the same channel in the same cycle leaves pending[i] set.
REQ-017 SHALL set irq_drop[i] when rise[i] occurs while pending[i] is set and not being granted in that cycle.
REQ-018 SHALL increment irq_count channel i on rise[i], saturating at 2^CNT_W-1 with no wrap.
REQ-019 SHALL clear all counters and irq_drop on slot_interrupt; simultaneous rise[i] yields count 1 and the drop condition of that cycle sets irq_drop[i].
REQ-020 SHALL implement FSM states IDLE, ASSERT, GAP.
REQ-021 IDLE: if any pending bit is set, grant one channel round-robin starting at last_grant+1 modulo NUM_CH, load irq_ch_id and last_grant, go ASSERT.
REQ-022 ASSERT: dsp_receive_interrupt high for exactly PULSE_LEN cycles, then GAP if GAP_LEN>0, else IDLE.
REQ-023 GAP: dsp_receive_interrupt low for exactly GAP_LEN cycles, then IDLE.
REQ-024 Latency: read_quest first sampled high at edge k produces dsp_receive_interrupt high after edge k+2 when FSM is IDLE.
REQ-025 SHALL hold dsp_receive_interrupt low for at least one cycle between consecutive pulses.
REQ-026 irq_ch_id SHALL be stable throughout a pulse and hold its last value otherwise.
REQ-027 slot_interrupt SHALL NOT affect pending, FSM, or pulse timing.

Reset
REQ-028 On cfg_rst: dsp_receive_interrupt, busy, irq_count, irq_drop, irq_ch_id, pending, read_quest_dl, and pulse/gap counters all 0; FSM IDLE; last_grant NUM_CH-1, so channel 0 wins first.
REQ-029 Reset asserted mid-pulse SHALL drop the interrupt low immediately and discard pending requests.

Configuration
REQ-030 With DSP_IRQ_ACK_EN defined: irq_ack high in ASSERT SHALL end the pulse, low from the next cycle, then GAP/IDLE per REQ-022; irq_ack in other states is ignored.
REQ-031 Without DSP_IRQ_ACK_EN: the irq_ack port SHALL remain present, and pulses always last PULSE_LEN cycles.

Structure
REQ-032 Package dsp_irq_pkg SHALL hold the FSM state enum, default parameter constants, and the channel-id width function.
REQ-033 Round-robin selection SHALL be sub-module irq_rr_arbiter (inputs pending and last_grant; outputs grant_valid and grant_id; combinational).

Verification
REQ-034 Single channel 0 rises at edge 10 -> interrupt high on edges 12..111, low at 112, irq_ch_id=0, irq_count ch0=1.
REQ-035 Channels 1 and 3 rise together after reset -> pulses for ch1 then ch3, separated by 4 low cycles; no drops.
REQ-036 Channel 2 toggles twice during an active pulse, with the first toggle left pending -> irq_drop[2]=1 and irq_count ch2=2; slot_interrupt then clears both to 0.
REQ-037 With CNT_W=3, ch0 rises 10 times -> count saturates at 7.
REQ-038 With DSP_IRQ_ACK_EN defined, irq_ack in the 5th ASSERT cycle -> pulse is 5 cycles long; without the macro, the pulse stays 100 cycles.
REQ-039 cfg_rst in the 50th pulse cycle -> all outputs 0, and no pulse follows after release.
